execute_mc: RTL
===============

EXECUTE_MC -- requirements
Module: execute_mc

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (legal 8..64).
REQ-002 Parameter CNTW, default $clog2(WIDTH)+1, iteration counter width.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 validE  in  1  instruction present in execute stage this cycle.
REQ-006 ALUSrcE  in  1  0: B operand from forwarded WriteDataE; 1: ExtImmE.
REQ-007 ALUControlE  in  4  operation select (REQ-013/014).
REQ-008 ForwardAE, ForwardBE  in  2 each  00 register value, 01 ResultW, 10 ALUResultM, 11 register value.
REQ-009 SrcAE, WriteDataE, ExtImmE, ResultW, ALUResultM  in  WIDTH each  operands and forwarding sources.
REQ-010 ALUResultE, SrcBE, WriteDataFwdE  out  WIDTH each  result, selected B operand, forwarded store data.
REQ-011 ALUFlags  out  4  {N,Z,C,V}.
REQ-012 BusyE  out  1  stall request to hazard unit; DoneE  out  1  multi-cycle result valid.

Function
REQ-013 Single-cycle ops, combinational, independent of FSM: 0000 ADD, 0001 SUB (a-b), 0010 AND, 0011 ORR, 0100 EOR, 0101 LSL by b[log2 WIDTH-1:0], 0110 LSR same, 0111 MOV (result=b).
REQ-014 Multi-cycle ops: 1000 MUL (low WIDTH bits, unsigned shift-add), 1001 DIVU quotient, 1010 REMU remainder (restoring division); 1011-1111 treated as MOV.
REQ-015 Forwarding: A = mux(ForwardAE); WriteDataFwdE = mux(ForwardBE) over WriteDataE; SrcBE = ALUSrcE ? ExtImmE : WriteDataFwdE.
REQ-016 Flags: ADD/SUB full NZCV (C = carry out / no-borrow, V = signed overflow); logic, shift, MOV, MUL, DIVU, REMU: N=msb, Z=(result==0), C=0, V=0.
REQ-017 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-018 IDLE & validE & multi-cycle op: capture A, B, op into internal registers, counter=0, go RUN (accept cycle = cycle 0).
REQ-019 RUN: one iteration per cycle; after WIDTH iterations (cycles 1..WIDTH) go DONE.
REQ-020 DONE: one cycle, DoneE=1, ALUResultE/ALUFlags from result register; unconditional return to IDLE.
REQ-021 BusyE = (IDLE & validE & multi-cycle op) | RUN; low in DONE so pipeline advances exactly once.
REQ-022 Total multi-cycle latency WIDTH+1 cycles from accept to DoneE; BusyE high WIDTH+1 cycles.
REQ-023 While BusyE, ALUResultE = 0 and operand inputs are ignored (captured copies used); upstream holds inputs stable.
REQ-024 IDLE with single-cycle op or validE=0: ALUResultE combinational, DoneE=0, BusyE=0.
REQ-025 Divide by zero: no exception, normal latency; quotient all ones, remainder = dividend.
REQ-026 MUL overflow: upper product bits discarded, no flag.
REQ-027 validE in DONE ignored; next instruction accepted in following IDLE cycle.

Reset
REQ-028 reset=1 at any edge: state IDLE, counter 0, internal operand/result registers 0, BusyE=0, DoneE=0; in-flight multi-cycle op aborted, no DoneE pulse.
REQ-029 First operation accepted on the first edge with reset=0.

Verification (WIDTH=32)
REQ-030 ADD 0x7FFFFFFF+1, ForwardAE=00 -> same-cycle ALUResultE=0x80000000, flags N=1,Z=0,C=0,V=1, BusyE=0.
REQ-031 MUL 7*6 at cycle 0 -> BusyE high cycles 0..32, DoneE and ALUResultE=42 at cycle 33 only, BusyE=0 at cycle 33.
REQ-032 DIVU 100/7 then REMU 100/7 back-to-back -> 14 at first DoneE, 2 at second; second accepted cycle after first DONE.
REQ-033 DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234; latency 33.
REQ-034 ForwardBE=10, ALUSrcE=0, ALUMResultM=5, WriteDataE=9, SUB with A=8 -> SrcBE=5, WriteDataFwdE=5, result 3, C=1.
REQ-035 reset asserted at cycle 10 of a DIVU -> next cycle IDLE, BusyE=0, no DoneE; new MUL 3*3 completes 9 with full latency.

Source files
------------

// File: rtl/execute_mc_if.sv
// ----------------------------------------------------------------------------
// execute_mc_if
// Bundles the execute-stage operand, control and result signals that pass
// between the pipeline (master) and the execute unit (slave).
//   master : drives validE, ALUSrcE, ALUControlE, ForwardAE/BE, SrcAE,
//            WriteDataE, ExtImmE, ResultW, ALUResultM; samples the results.
//   slave  : samples the operands/controls; drives ALUResultE, SrcBE,
//            WriteDataFwdE, ALUFlags {N,Z,C,V}, BusyE, DoneE.
// ----------------------------------------------------------------------------
interface execute_mc_if #(
  parameter int WIDTH = 32
);
  logic             validE;
  logic             ALUSrcE;
  logic [3:0]       ALUControlE;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] WriteDataE;
  logic [WIDTH-1:0] ExtImmE;
  logic [WIDTH-1:0] ResultW;
  logic [WIDTH-1:0] ALUResultM;
  logic [WIDTH-1:0] ALUResultE;
  logic [WIDTH-1:0] SrcBE;
  logic [WIDTH-1:0] WriteDataFwdE;
  logic [3:0]       ALUFlags;
  logic             BusyE;
  logic             DoneE;

  modport master (
    output validE, ALUSrcE, ALUControlE, ForwardAE, ForwardBE,
           SrcAE, WriteDataE, ExtImmE, ResultW, ALUResultM,
    input  ALUResultE, SrcBE, WriteDataFwdE, ALUFlags, BusyE, DoneE
  );

  modport slave (
    input  validE, ALUSrcE, ALUControlE, ForwardAE, ForwardBE,
           SrcAE, WriteDataE, ExtImmE, ResultW, ALUResultM,
    output ALUResultE, SrcBE, WriteDataFwdE, ALUFlags, BusyE, DoneE
  );
endinterface

// File: rtl/execute_mc.sv
// ----------------------------------------------------------------------------
// execute_mc
// Execute stage with operand forwarding, a combinational single-cycle ALU
// and an iterative unit for MUL (shift-add), DIVU and REMU (restoring
// division).  Iterative ops take WIDTH+1 cycles from accept to DoneE and
// hold BusyE high for the whole time except the DONE cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   ex    : execute_mc_if.slave (operands, controls, results, BusyE/DoneE)
// ----------------------------------------------------------------------------
module execute_mc #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  execute_mc_if.slave   ex
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_ORR  = 4'b0011;
  localparam logic [3:0] OP_EOR  = 4'b0100;
  localparam logic [3:0] OP_LSL  = 4'b0101;
  localparam logic [3:0] OP_LSR  = 4'b0110;
  localparam logic [3:0] OP_MOV  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Forwarding source select: 01 writeback, 10 memory stage, else register.
  function automatic logic [WIDTH-1:0] fwd_mux(
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] reg_v,
    input logic [WIDTH-1:0] res_w,
    input logic [WIDTH-1:0] alu_m
  );
    logic [WIDTH-1:0] v;
    case (sel)
      2'b01:   v = res_w;
      2'b10:   v = alu_m;
      default: v = reg_v;
    endcase
    return v;
  endfunction

  // Operand path
  logic [WIDTH-1:0] src_a_s;
  logic [WIDTH-1:0] wd_fwd_s;
  logic [WIDTH-1:0] src_b_s;
  logic [SHW-1:0]   shamt_s;

  // Single-cycle ALU
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] sc_res_s;
  logic             sc_c_s;
  logic             sc_v_s;
  logic [3:0]       sc_flags_s;

  // Control
  logic             is_mc_s;
  logic             accept_s;
  logic             busy_s;

  // Iterative unit state
  state_t           state_r;
  logic [CNTW-1:0]  cnt_r;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] x_r;    // MUL: shifting multiplicand; DIV: dividend -> quotient
  logic [WIDTH-1:0] y_r;    // MUL: shifting multiplier;   DIV: divisor
  logic [WIDTH-1:0] acc_r;  // MUL: partial product;       DIV: partial remainder
  logic [WIDTH-1:0] res_r;
  logic             done_r;

  // Iteration next-state
  logic [WIDTH:0]   rem_sh_s;
  logic             ge_s;
  logic [WIDTH-1:0] x_nxt_s;
  logic [WIDTH-1:0] y_nxt_s;
  logic [WIDTH-1:0] acc_nxt_s;
  logic [WIDTH-1:0] res_nxt_s;

  // Outputs
  logic [WIDTH-1:0] alu_res_s;
  logic [3:0]       alu_flags_s;

  // Forwarding muxes and B-operand select.
  always_comb begin
    src_a_s  = fwd_mux(ex.ForwardAE, ex.SrcAE, ex.ResultW, ex.ALUResultM);
    wd_fwd_s = fwd_mux(ex.ForwardBE, ex.WriteDataE, ex.ResultW, ex.ALUResultM);
    if (ex.ALUSrcE) begin
      src_b_s = ex.ExtImmE;
    end else begin
      src_b_s = wd_fwd_s;
    end
    shamt_s = src_b_s[SHW-1:0];
  end

  // Accept / stall decode.
  always_comb begin
    is_mc_s  = (ex.ALUControlE == OP_MUL) || (ex.ALUControlE == OP_DIVU) ||
               (ex.ALUControlE == OP_REMU);
    accept_s = (state_r == ST_IDLE) && ex.validE && is_mc_s;
    busy_s   = accept_s || (state_r == ST_RUN);
  end

  // Single-cycle ALU and its flags.
  always_comb begin
    sum_s    = {(WIDTH+1){1'b0}};
    sc_res_s = {WIDTH{1'b0}};
    sc_c_s   = 1'b0;
    sc_v_s   = 1'b0;
    case (ex.ALUControlE)
      OP_ADD: begin
        sum_s    = {1'b0, src_a_s} + {1'b0, src_b_s};
        sc_res_s = sum_s[WIDTH-1:0];
        sc_c_s   = sum_s[WIDTH];
        sc_v_s   = (src_a_s[WIDTH-1] == src_b_s[WIDTH-1]) &&
                   (sum_s[WIDTH-1] != src_a_s[WIDTH-1]);
      end
      OP_SUB: begin
        // a + ~b + 1: carry out is the ARM-style "no borrow" flag.
        sum_s    = {1'b0, src_a_s} + {1'b0, ~src_b_s} + {{WIDTH{1'b0}}, 1'b1};
        sc_res_s = sum_s[WIDTH-1:0];
        sc_c_s   = sum_s[WIDTH];
        sc_v_s   = (src_a_s[WIDTH-1] != src_b_s[WIDTH-1]) &&
                   (sum_s[WIDTH-1] != src_a_s[WIDTH-1]);
      end
      OP_AND:  sc_res_s = src_a_s & src_b_s;
      OP_ORR:  sc_res_s = src_a_s | src_b_s;
      OP_EOR:  sc_res_s = src_a_s ^ src_b_s;
      OP_LSL:  sc_res_s = src_a_s << shamt_s;
      OP_LSR:  sc_res_s = src_a_s >> shamt_s;
      OP_MOV:  sc_res_s = src_b_s;
      OP_MUL, OP_DIVU, OP_REMU: sc_res_s = {WIDTH{1'b0}};
      default: sc_res_s = src_b_s;
    endcase
    sc_flags_s = {sc_res_s[WIDTH-1], (sc_res_s == {WIDTH{1'b0}}), sc_c_s, sc_v_s};
  end

  // One shift-add or restoring-division step from the captured registers.
  always_comb begin
    rem_sh_s  = {acc_r, x_r[WIDTH-1]};
    ge_s      = (rem_sh_s >= {1'b0, y_r});
    x_nxt_s   = x_r;
    y_nxt_s   = y_r;
    acc_nxt_s = acc_r;
    if (op_r == OP_MUL) begin
      acc_nxt_s = acc_r + (y_r[0] ? x_r : {WIDTH{1'b0}});
      x_nxt_s   = {x_r[WIDTH-2:0], 1'b0};
      y_nxt_s   = {1'b0, y_r[WIDTH-1:1]};
    end else if (ge_s) begin
      // True difference is below the divisor, so the low WIDTH bits are exact.
      // A zero divisor always takes this branch: quotient all ones and the
      // remainder ends up holding the dividend.
      acc_nxt_s = rem_sh_s[WIDTH-1:0] - y_r;
      x_nxt_s   = {x_r[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt_s = rem_sh_s[WIDTH-1:0];
      x_nxt_s   = {x_r[WIDTH-2:0], 1'b0};
    end
    if (op_r == OP_DIVU) begin
      res_nxt_s = x_nxt_s;
    end else begin
      res_nxt_s = acc_nxt_s;
    end
  end

  // Iterative-unit FSM: IDLE -> RUN (WIDTH steps) -> DONE (one cycle) -> IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNTW{1'b0}};
      op_r    <= 4'b0000;
      x_r     <= {WIDTH{1'b0}};
      y_r     <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r    <= ex.ALUControlE;
            x_r     <= src_a_s;
            y_r     <= src_b_s;
            acc_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CNTW{1'b0}};
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          x_r   <= x_nxt_s;
          y_r   <= y_nxt_s;
          acc_r <= acc_nxt_s;
          cnt_r <= cnt_r + CNTW'(1);
          if (cnt_r == CNTW'(WIDTH - 1)) begin
            res_r   <= res_nxt_s;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          // validE is deliberately ignored here; the next op is taken in IDLE.
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Result/flag select: zero while stalled, held result in DONE, else ALU.
  always_comb begin
    if (busy_s) begin
      alu_res_s   = {WIDTH{1'b0}};
      alu_flags_s = 4'b0100;
    end else if (state_r == ST_DONE) begin
      alu_res_s   = res_r;
      alu_flags_s = {res_r[WIDTH-1], (res_r == {WIDTH{1'b0}}), 2'b00};
    end else begin
      alu_res_s   = sc_res_s;
      alu_flags_s = sc_flags_s;
    end
  end

  assign ex.ALUResultE    = alu_res_s;
  assign ex.ALUFlags      = alu_flags_s;
  assign ex.SrcBE         = src_b_s;
  assign ex.WriteDataFwdE = wd_fwd_s;
  assign ex.BusyE         = busy_s;
  assign ex.DoneE         = done_r;

endmodule
